// File: rtl/ipa_lsu_pkg.sv
// Shared definitions for the IPA load/store arbiter: FSM state encoding and tile-count constants.
package ipa_lsu_pkg;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NB_ROWS_DEF = 4;
  localparam int NB_COLS_DEF = 4;
  localparam int NB_TILES    = NB_ROWS_DEF * NB_COLS_DEF;
  localparam int IDX_W       = idxWidth(NB_TILES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ACK   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/ipa_lsu_arbiter_if.sv
// Tile-side and memory-side bus of the IPA load/store arbiter; the arbiter uses the slave modport.
interface ipa_lsu_arbiter_if
  import ipa_lsu_pkg::*;
#(
  parameter int NB_ROWS = NB_ROWS_DEF,
  parameter int NB_COLS = NB_COLS_DEF,
  parameter int DWIDTH  = 32
);
  localparam int NbTiles = NB_ROWS * NB_COLS;

  logic [NbTiles-1:0]        Load_Store_Req_I;
  logic [NbTiles-1:0]        Load_Store_Data_Req_I;
  logic [NbTiles*DWIDTH-1:0] Load_Store_Addr_I;
  logic [NbTiles*DWIDTH-1:0] Store_Data_I;
  logic [NbTiles-1:0]        Load_Store_Grant_O;
  logic [NbTiles-1:0]        Data_Req_Valid_O;
  logic [DWIDTH-1:0]         Load_Data_O;

  logic                      Mem_Req_O;
  logic                      Mem_We_O;
  logic [DWIDTH-1:0]         Mem_Addr_O;
  logic [DWIDTH-1:0]         Mem_Wdata_O;
  logic                      Mem_Gnt_I;
  logic                      Mem_Rvalid_I;
  logic [DWIDTH-1:0]         Mem_Rdata_I;

  modport slave (
    input  Load_Store_Req_I, Load_Store_Data_Req_I, Load_Store_Addr_I, Store_Data_I,
    input  Mem_Gnt_I, Mem_Rvalid_I, Mem_Rdata_I,
    output Load_Store_Grant_O, Data_Req_Valid_O, Load_Data_O,
    output Mem_Req_O, Mem_We_O, Mem_Addr_O, Mem_Wdata_O
  );

  modport master (
    output Load_Store_Req_I, Load_Store_Data_Req_I, Load_Store_Addr_I, Store_Data_I,
    output Mem_Gnt_I, Mem_Rvalid_I, Mem_Rdata_I,
    input  Load_Store_Grant_O, Data_Req_Valid_O, Load_Data_O,
    input  Mem_Req_O, Mem_We_O, Mem_Addr_O, Mem_Wdata_O
  );

endinterface

// File: rtl/rr_arbiter_ipa.sv
// Round-robin picker: returns the first requesting tile at or after the pointer, as one-hot and index.
module rr_arbiter_ipa
  import ipa_lsu_pkg::*;
#(
  parameter int N    = NB_TILES,
  parameter int IDXW = IDX_W
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  logic [IDXW-1:0] cand;

  // Walk offsets from farthest to nearest so the requester closest to the pointer is the one kept.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDXW'((int'(ptr_i) + i) % N);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipa_lsu_arbiter.sv
// Serialises PE-tile load/store requests onto one memory port, one transaction at a time.
// Optional performance counters are built only when IPA_LSU_PERF_EN is defined.
module ipa_lsu_arbiter
  import ipa_lsu_pkg::*;
#(
  parameter int NB_ROWS = NB_ROWS_DEF,
  parameter int NB_COLS = NB_COLS_DEF,
  parameter int DWIDTH  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  ipa_lsu_arbiter_if.slave bus,
  output logic             Busy_O,
  output logic [31:0]      Perf_Loads_O,
  output logic [31:0]      Perf_Stores_O,
  output logic [31:0]      Perf_Wait_O
);

  localparam int NbTiles = NB_ROWS * NB_COLS;
  localparam int IdxW    = idxWidth(NbTiles);

  lsu_state_t        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [DWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] loadData_q, loadData_d;
  logic              isStore_q, isStore_d;

  logic [NbTiles-1:0] pickGnt;
  logic [IdxW-1:0]    pickIdx;
  logic               pickValid;
  logic [DWIDTH-1:0]  tileAddr  [NbTiles];
  logic [DWIDTH-1:0]  tileWdata [NbTiles];

  for (genvar g = 0; g < NbTiles; g++) begin : g_unpack
    assign tileAddr[g]  = bus.Load_Store_Addr_I[g*DWIDTH +: DWIDTH];
    assign tileWdata[g] = bus.Store_Data_I[g*DWIDTH +: DWIDTH];
  end

  rr_arbiter_ipa #(
    .N    (NbTiles),
    .IDXW (IdxW)
  ) u_rr (
    .req_i   (bus.Load_Store_Req_I),
    .ptr_i   (ptr_q),
    .gnt_o   (pickGnt),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      loadData_q <= '0;
      isStore_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      loadData_q <= loadData_d;
      isStore_q  <= isStore_d;
    end
  end

  // Arbitration only happens in IDLE, so requests seen in ACK are naturally ignored.
  always_comb begin
    state_d                = state_q;
    idx_d                  = idx_q;
    ptr_d                  = ptr_q;
    addr_d                 = addr_q;
    wdata_d                = wdata_q;
    loadData_d             = loadData_q;
    isStore_d              = isStore_q;
    bus.Mem_Req_O          = 1'b0;
    bus.Mem_We_O           = 1'b0;
    bus.Mem_Addr_O         = '0;
    bus.Mem_Wdata_O        = '0;
    bus.Load_Store_Grant_O = '0;
    bus.Data_Req_Valid_O   = '0;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          idx_d     = pickIdx;
          ptr_d     = (pickIdx == IdxW'(NbTiles - 1)) ? '0 : pickIdx + 1'b1;
          addr_d    = tileAddr[pickIdx];
          wdata_d   = tileWdata[pickIdx];
          isStore_d = |(pickGnt & bus.Load_Store_Data_Req_I);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        bus.Mem_Req_O   = 1'b1;
        bus.Mem_We_O    = isStore_q;
        bus.Mem_Addr_O  = addr_q;
        bus.Mem_Wdata_O = wdata_q;
        if (bus.Mem_Gnt_I) begin
          state_d = isStore_q ? ACK : RESP;
        end
      end
      RESP: begin
        if (bus.Mem_Rvalid_I) begin
          loadData_d = bus.Mem_Rdata_I;
          state_d    = ACK;
        end
      end
      ACK: begin
        bus.Load_Store_Grant_O[idx_q] = 1'b1;
        bus.Data_Req_Valid_O[idx_q]   = !isStore_q;
        state_d                       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Load_Data_O = loadData_q;
  assign Busy_O          = (state_q != IDLE);

`ifdef IPA_LSU_PERF_EN
  logic [31:0] perfLoads_q, perfStores_q, perfWait_q;

  // Saturating counters: completions are counted in ACK, stall time across ISSUE and RESP.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      perfLoads_q  <= '0;
      perfStores_q <= '0;
      perfWait_q   <= '0;
    end else begin
      if (state_q == ACK && !isStore_q && perfLoads_q != '1) begin
        perfLoads_q <= perfLoads_q + 32'd1;
      end
      if (state_q == ACK && isStore_q && perfStores_q != '1) begin
        perfStores_q <= perfStores_q + 32'd1;
      end
      if ((state_q == ISSUE || state_q == RESP) && perfWait_q != '1) begin
        perfWait_q <= perfWait_q + 32'd1;
      end
    end
  end

  assign Perf_Loads_O  = perfLoads_q;
  assign Perf_Stores_O = perfStores_q;
  assign Perf_Wait_O   = perfWait_q;
`else
  assign Perf_Loads_O  = '0;
  assign Perf_Stores_O = '0;
  assign Perf_Wait_O   = '0;
`endif

endmodule

// File: tb/tb_ipa_lsu_arbiter.sv
// Directed bench for ipa_lsu_arbiter: a table of single transactions plus contention, reset and perf sequences.
module tb_ipa_lsu_arbiter;
  import ipa_lsu_pkg::*;

  localparam int NT = NB_TILES;
  localparam int DW = 32;

  typedef struct {
    int          tile;
    logic        isStore;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gntWait;
    int          rvWait;
    logic [31:0] rdata;
    int          expLatency;
    logic [31:0] expLoadData;
  } txn_t;

  logic        clock = 1'b0;
  logic        resetN;
  logic        busy;
  logic [31:0] perfLoads, perfStores, perfWait;
  int          checkCount = 0;
  int          passCount  = 0;
  int          served[$];
  txn_t        vec[4];
  txn_t        perfVec[5];

  always #5 clock = ~clock;

  ipa_lsu_arbiter_if #(.NB_ROWS(4), .NB_COLS(4), .DWIDTH(DW)) bus ();

  ipa_lsu_arbiter #(.NB_ROWS(4), .NB_COLS(4), .DWIDTH(DW)) dut (
    .Clk           (clock),
    .Reset         (resetN),
    .bus           (bus),
    .Busy_O        (busy),
    .Perf_Loads_O  (perfLoads),
    .Perf_Stores_O (perfStores),
    .Perf_Wait_O   (perfWait)
  );

  // Every comparison in the bench funnels through here so the counters stay honest.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic clearInputs();
    bus.Load_Store_Req_I      = '0;
    bus.Load_Store_Data_Req_I = '0;
    bus.Load_Store_Addr_I     = '0;
    bus.Store_Data_I          = '0;
    bus.Mem_Gnt_I             = 1'b0;
    bus.Mem_Rvalid_I          = 1'b0;
    bus.Mem_Rdata_I           = '0;
  endtask

  task automatic doReset();
    @(negedge clock);
    clearInputs();
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
  endtask

  // One tile transaction with a scripted memory; latency counts cycles after the IDLE cycle that saw the request.
  task automatic applyStimulus(input string tag, input txn_t t);
    int            reqCycles  = 0;
    int            respCycles = 0;
    int            pulseCyc   = -1;
    logic          respPhase  = 1'b0;
    logic          busOk      = 1'b1;
    logic [NT-1:0] gntVec     = '0;
    logic [NT-1:0] drvVec     = '0;
    logic [NT-1:0] expGnt     = '0;
    expGnt[t.tile] = 1'b1;
    @(negedge clock);
    bus.Load_Store_Req_I[t.tile]      = 1'b1;
    bus.Load_Store_Data_Req_I[t.tile] = t.isStore;
    bus.Load_Store_Addr_I[t.tile*DW +: DW] = t.addr;
    bus.Store_Data_I[t.tile*DW +: DW]      = t.wdata;
    for (int cyc = 1; cyc <= 60 && pulseCyc < 0; cyc++) begin
      @(negedge clock);
      bus.Mem_Gnt_I    = 1'b0;
      bus.Mem_Rvalid_I = 1'b0;
      bus.Mem_Rdata_I  = 32'hBAD0_BAD0;
      if (bus.Load_Store_Grant_O != '0) begin
        pulseCyc = cyc;
        gntVec   = bus.Load_Store_Grant_O;
        drvVec   = bus.Data_Req_Valid_O;
        bus.Load_Store_Req_I[t.tile] = 1'b0;
      end else if (bus.Mem_Req_O) begin
        if (bus.Mem_Addr_O !== t.addr || bus.Mem_We_O !== t.isStore ||
            (t.isStore && bus.Mem_Wdata_O !== t.wdata)) busOk = 1'b0;
        reqCycles++;
        if (reqCycles > t.gntWait) begin
          bus.Mem_Gnt_I = 1'b1;
          respPhase     = !t.isStore;
        end
      end else if (respPhase) begin
        respCycles++;
        if (respCycles > t.rvWait) begin
          bus.Mem_Rvalid_I = 1'b1;
          bus.Mem_Rdata_I  = t.rdata;
          respPhase        = 1'b0;
        end
      end
    end
    @(negedge clock);
    checkOutput({tag, " latency"}, 64'(pulseCyc), 64'(t.expLatency));
    checkOutput({tag, " grant vector"}, 64'(gntVec), 64'(expGnt));
    checkOutput({tag, " data valid vector"}, 64'(drvVec), t.isStore ? 64'd0 : 64'(expGnt));
    checkOutput({tag, " mem req fields stable"}, 64'(busOk), 64'd1);
    checkOutput({tag, " mem req cycles"}, 64'(reqCycles), 64'(t.gntWait + 1));
    checkOutput({tag, " grant single pulse"}, 64'(bus.Load_Store_Grant_O), 64'd0);
    checkOutput({tag, " busy after ack"}, 64'(busy), 64'd0);
    checkOutput({tag, " load data"}, 64'(bus.Load_Data_O), 64'(t.expLoadData));
  endtask

  // Several tiles load at once against a zero-wait memory; rearmTile re-requests once right after its first grant.
  task automatic runContention(input logic [NT-1:0] mask, input int rearmTile, input int nExpect);
    logic respPhase = 1'b0;
    logic rearmNow  = 1'b0;
    logic rearmed   = 1'b0;
    served.delete();
    @(negedge clock);
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        bus.Load_Store_Req_I[i]           = 1'b1;
        bus.Load_Store_Data_Req_I[i]      = 1'b0;
        bus.Load_Store_Addr_I[i*DW +: DW] = 32'(i * 4);
      end
    end
    for (int cyc = 0; cyc < 80 && served.size() < nExpect; cyc++) begin
      @(negedge clock);
      bus.Mem_Gnt_I    = 1'b0;
      bus.Mem_Rvalid_I = 1'b0;
      if (rearmNow) begin
        bus.Load_Store_Req_I[rearmTile] = 1'b1;
        rearmNow = 1'b0;
      end
      if (bus.Load_Store_Grant_O != '0) begin
        for (int i = 0; i < NT; i++) begin
          if (bus.Load_Store_Grant_O[i]) begin
            served.push_back(i);
            bus.Load_Store_Req_I[i] = 1'b0;
            if (i == rearmTile && !rearmed) begin
              rearmNow = 1'b1;
              rearmed  = 1'b1;
            end
          end
        end
      end else if (bus.Mem_Req_O) begin
        bus.Mem_Gnt_I = 1'b1;
        respPhase     = 1'b1;
      end else if (respPhase) begin
        bus.Mem_Rvalid_I = 1'b1;
        bus.Mem_Rdata_I  = 32'h0000_1000;
        respPhase        = 1'b0;
      end
    end
    bus.Load_Store_Req_I = '0;
    checkOutput("contention service count", 64'(served.size()), 64'(nExpect));
  endtask

  function automatic int servedAt(input int k);
    return (served.size() > k) ? served[k] : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic        lateOk;
    logic [31:0] expLoads, expStores, expWait;

    vec[0] = '{5,  1'b0, 32'h0000_0100, 32'h0,          0, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
    vec[1] = '{0,  1'b1, 32'h0000_0040, 32'h0000_1234,  3, 0, 32'h0,         5, 32'hDEAD_BEEF};
    vec[2] = '{15, 1'b0, 32'h0000_01FC, 32'h0,          1, 2, 32'hCAFE_F00D, 6, 32'hCAFE_F00D};
    vec[3] = '{7,  1'b1, 32'h0000_0080, 32'hA5A5_A5A5,  0, 0, 32'h0,         2, 32'hCAFE_F00D};

    perfVec[0] = '{1, 1'b0, 32'h0000_0010, 32'h0,         2, 0, 32'h0000_0011, 5, 32'h0000_0011};
    perfVec[1] = '{2, 1'b1, 32'h0000_0020, 32'h0000_00AA, 2, 0, 32'h0,         4, 32'h0000_0011};
    perfVec[2] = '{3, 1'b0, 32'h0000_0030, 32'h0,         2, 0, 32'h0000_0022, 5, 32'h0000_0022};
    perfVec[3] = '{4, 1'b1, 32'h0000_0040, 32'h0000_00BB, 2, 0, 32'h0,         4, 32'h0000_0022};
    perfVec[4] = '{6, 1'b0, 32'h0000_0060, 32'h0,         2, 0, 32'h0000_0033, 5, 32'h0000_0033};

    clearInputs();
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset mem req", 64'(bus.Mem_Req_O), 64'd0);
    checkOutput("reset mem addr", 64'(bus.Mem_Addr_O), 64'd0);
    checkOutput("reset grant", 64'(bus.Load_Store_Grant_O), 64'd0);
    checkOutput("reset data valid", 64'(bus.Data_Req_Valid_O), 64'd0);
    checkOutput("reset load data", 64'(bus.Load_Data_O), 64'd0);
    checkOutput("reset perf loads", 64'(perfLoads), 64'd0);
    checkOutput("reset perf wait", 64'(perfWait), 64'd0);

    for (int n = 0; n < 4; n++) begin
      applyStimulus($sformatf("txn%0d", n), vec[n]);
    end

    $display("[TB] contention: tiles 1, 3, 15 from reset, tile 1 re-requests");
    doReset();
    runContention(16'h800A, 1, 4);
    checkOutput("contention order 0", 64'(servedAt(0)), 64'd1);
    checkOutput("contention order 1", 64'(servedAt(1)), 64'd3);
    checkOutput("contention order 2", 64'(servedAt(2)), 64'd15);
    checkOutput("contention order 3", 64'(servedAt(3)), 64'd1);

    $display("[TB] reset while waiting for read data");
    @(negedge clock);
    bus.Load_Store_Req_I[2]           = 1'b1;
    bus.Load_Store_Data_Req_I[2]      = 1'b0;
    bus.Load_Store_Addr_I[2*DW +: DW] = 32'h0000_0200;
    @(negedge clock);
    checkOutput("midreset issue req", 64'(bus.Mem_Req_O), 64'd1);
    bus.Mem_Gnt_I = 1'b1;
    @(negedge clock);
    bus.Mem_Gnt_I = 1'b0;
    checkOutput("midreset busy before", 64'(busy), 64'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset mem req", 64'(bus.Mem_Req_O), 64'd0);
    checkOutput("midreset grant", 64'(bus.Load_Store_Grant_O), 64'd0);
    checkOutput("midreset load data", 64'(bus.Load_Data_O), 64'd0);
    checkOutput("midreset perf loads", 64'(perfLoads), 64'd0);
    bus.Load_Store_Req_I = '0;
    @(negedge clock);
    resetN           = 1'b1;
    bus.Mem_Rvalid_I = 1'b1;
    bus.Mem_Rdata_I  = 32'h5555_5555;
    lateOk = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (bus.Load_Store_Grant_O != '0 || bus.Data_Req_Valid_O != '0 || busy) lateOk = 1'b0;
    end
    bus.Mem_Rvalid_I = 1'b0;
    checkOutput("late rvalid no pulse", 64'(lateOk), 64'd1);
    checkOutput("late rvalid load data", 64'(bus.Load_Data_O), 64'd0);

    runContention(16'h0009, -1, 2);
    checkOutput("pointer after reset first", 64'(servedAt(0)), 64'd0);
    checkOutput("pointer after reset second", 64'(servedAt(1)), 64'd3);

    $display("[TB] perf counters: 3 loads, 2 stores, 2 grant wait cycles each");
    doReset();
    for (int n = 0; n < 5; n++) begin
      applyStimulus($sformatf("perf%0d", n), perfVec[n]);
    end
`ifdef IPA_LSU_PERF_EN
    expLoads  = 32'd3;
    expStores = 32'd2;
    expWait   = 32'd18;
`else
    expLoads  = 32'd0;
    expStores = 32'd0;
    expWait   = 32'd0;
`endif
    checkOutput("perf loads", 64'(perfLoads), 64'(expLoads));
    checkOutput("perf stores", 64'(perfStores), 64'(expStores));
    checkOutput("perf wait", 64'(perfWait), 64'(expWait));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
